// File: rtl/ppi_pkg.sv
// Shared constants, state type and request payload for the PPI bus master.
package ppi_pkg;

  localparam int unsigned TIMER_W = 4;
  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned DATA_W  = 8;

  localparam logic [ADDR_W-1:0] PPI_ADDR_A    = 2'b00;
  localparam logic [ADDR_W-1:0] PPI_ADDR_B    = 2'b01;
  localparam logic [ADDR_W-1:0] PPI_ADDR_C    = 2'b10;
  localparam logic [ADDR_W-1:0] PPI_ADDR_CTRL = 2'b11;

  localparam logic [DATA_W-1:0] PPI_CTRL_DEFAULT = 8'h80;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } ppiState_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ppiReq_t;

endpackage

// File: rtl/ppi_bus_master_if.sv
// Host request/response and PPI pin bundle; master = bus master block, slave = host/PPI side.
interface ppi_bus_master_if;
  import ppi_pkg::*;

  logic              ReqValid;
  logic              ReqReady;
  logic              ReqWrite;
  logic [ADDR_W-1:0] ReqAddr;
  logic [DATA_W-1:0] ReqData;
  logic              RspValid;
  logic [DATA_W-1:0] RspData;
  logic              nCs;
  logic              nRe;
  logic              nWr;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] DOut;
  logic              DOe;
  logic [DATA_W-1:0] DIn;
  logic              Busy;

  modport master (
    input  ReqValid, ReqWrite, ReqAddr, ReqData, DIn,
    output ReqReady, RspValid, RspData, nCs, nRe, nWr, A, DOut, DOe, Busy
  );

  modport slave (
    output ReqValid, ReqWrite, ReqAddr, ReqData, DIn,
    input  ReqReady, RspValid, RspData, nCs, nRe, nWr, A, DOut, DOe, Busy
  );

endinterface

// File: rtl/ppi_bus_timer.sv
// Shared state-duration down-counter: load a value, count to zero, flag done.
module ppi_bus_timer
  import ppi_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] loadVal,
  output logic               done_c
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (count != '0) begin
      count <= count - TIMER_W'(1);
    end
  end

  assign done_c = (count == '0);

endmodule

// File: rtl/ppi_bus_master.sv
// 8255-style PPI bus master: sequences setup/strobe/hold cycles for host reads and writes.
// Optional PPI_MASTER_INIT_EN: writes INIT_WORD to the control register after reset.
module ppi_bus_master
  import ppi_pkg::*;
#(
  parameter int unsigned       SETUP_CYC  = 1,
  parameter int unsigned       STROBE_CYC = 2,
  parameter int unsigned       HOLD_CYC   = 1,
  parameter logic [DATA_W-1:0] INIT_WORD  = PPI_CTRL_DEFAULT
) (
  input  logic              Clk,
  input  logic              Reset,
  ppi_bus_master_if.master  bus
);

  // Timer counts down to zero, so each state lasts (load value + 1) cycles.
  localparam logic [TIMER_W-1:0] SETUP_LD  = TIMER_W'(SETUP_CYC - 1);
  localparam logic [TIMER_W-1:0] STROBE_LD = TIMER_W'(STROBE_CYC - 1);
  localparam logic [TIMER_W-1:0] HOLD_LD   = TIMER_W'(HOLD_CYC - 1);

  ppiState_t          state, stateNext;
  ppiReq_t            req, reqNext;
  logic               timerLoad;
  logic [TIMER_W-1:0] timerLoadVal;
  logic               timerDone;
  logic               initDone, initDoneNext;
  logic               rspValidNext;
  logic               captureEn;

`ifdef PPI_MASTER_INIT_EN
  localparam logic READY_AT_RESET = 1'b0;

  always_ff @(posedge Clk) begin
    if (Reset) initDone <= 1'b0;
    else       initDone <= initDoneNext;
  end

  assign initDoneNext = initDone | (state == HOLD && timerDone);
`else
  localparam logic READY_AT_RESET = 1'b1;

  assign initDone     = 1'b1;
  assign initDoneNext = 1'b1;
`endif

  ppi_bus_timer uTimer (
    .Clk     (Clk),
    .Reset   (Reset),
    .load    (timerLoad),
    .loadVal (timerLoadVal),
    .done_c  (timerDone)
  );

  // Next-state, request latch and timer control.
  always_comb begin
    stateNext    = state;
    reqNext      = req;
    timerLoad    = 1'b0;
    timerLoadVal = '0;
    rspValidNext = 1'b0;
    captureEn    = 1'b0;
    case (state)
      IDLE: begin
        if (!initDone) begin
          stateNext    = SETUP;
          timerLoad    = 1'b1;
          timerLoadVal = SETUP_LD;
          reqNext      = '{write: 1'b1, addr: PPI_ADDR_CTRL, data: INIT_WORD};
        end else if (bus.ReqValid) begin
          stateNext    = SETUP;
          timerLoad    = 1'b1;
          timerLoadVal = SETUP_LD;
          reqNext      = '{write: bus.ReqWrite, addr: bus.ReqAddr, data: bus.ReqData};
        end
      end
      SETUP: begin
        if (timerDone) begin
          stateNext    = STROBE;
          timerLoad    = 1'b1;
          timerLoadVal = STROBE_LD;
        end
      end
      STROBE: begin
        if (timerDone) begin
          stateNext    = HOLD;
          timerLoad    = 1'b1;
          timerLoadVal = HOLD_LD;
          captureEn    = !req.write;
        end
      end
      HOLD: begin
        if (timerDone) begin
          stateNext    = IDLE;
          rspValidNext = !req.write;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Pin outputs are registered from the next state so they change cleanly on the edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      req          <= '0;
      bus.nCs      <= 1'b1;
      bus.nRe      <= 1'b1;
      bus.nWr      <= 1'b1;
      bus.DOe      <= 1'b0;
      bus.Busy     <= 1'b0;
      bus.RspValid <= 1'b0;
      bus.RspData  <= '0;
      bus.ReqReady <= READY_AT_RESET;
    end else begin
      state        <= stateNext;
      req          <= reqNext;
      bus.nCs      <= (stateNext == IDLE);
      bus.Busy     <= (stateNext != IDLE);
      bus.nWr      <= !(stateNext == STROBE && reqNext.write);
      bus.nRe      <= !(stateNext == STROBE && !reqNext.write);
      bus.DOe      <= (stateNext != IDLE) && reqNext.write;
      bus.RspValid <= rspValidNext;
      bus.ReqReady <= (stateNext == IDLE) && initDoneNext;
      if (captureEn) bus.RspData <= bus.DIn;
    end
  end

  assign bus.A    = req.addr;
  assign bus.DOut = req.data;

endmodule

// File: tb/tb_ppi_bus_master.sv
// Self-checking bench for ppi_bus_master: transaction-schedule model plus directed and random traffic.
module tb_ppi_bus_master;
  import ppi_pkg::*;

  localparam int unsigned S  = 1;
  localparam int unsigned ST = 2;
  localparam int unsigned H  = 1;
  localparam int unsigned T  = S + ST + H;
  localparam logic [7:0]  IW = 8'h80;
`ifdef PPI_MASTER_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  ppi_bus_master_if bus ();

  ppi_bus_master #(
    .SETUP_CYC  (S),
    .STROBE_CYC (ST),
    .HOLD_CYC   (H),
    .INIT_WORD  (IW)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  bit chkEn  = 1'b0;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  // Model: a transaction occupies cycles 1..T after its accept edge;
  // strobe in cycles S+1..S+ST, read data taken on the edge ending cycle S+ST.
  bit         mAct      = 1'b0;
  int         mK        = 0;
  bit         mWr       = 1'b0;
  logic [1:0] mAddr     = '0;
  logic [7:0] mData     = '0;
  logic [7:0] mRsp      = '0;
  bit         mRspValid = 1'b0;
  bit         mInitDone = 1'b0;
  int         cyc       = 0;
  int         acceptCyc[$];

  always @(posedge Clk) begin
    cyc++;
    if (Reset) begin
      mAct = 1'b0; mK = 0; mWr = 1'b0; mAddr = '0; mData = '0;
      mRsp = '0; mRspValid = 1'b0; mInitDone = !INIT_EN;
    end else begin
      mRspValid = 1'b0;
      if (mAct) begin
        if (mK == int'(S + ST) && !mWr) mRsp = bus.DIn;
        if (mK == int'(T)) begin
          mAct = 1'b0;
          mRspValid = !mWr;
          mInitDone = 1'b1;
        end else begin
          mK++;
        end
      end else if (!mInitDone) begin
        mAct = 1'b1; mK = 1; mWr = 1'b1; mAddr = PPI_ADDR_CTRL; mData = IW;
      end else if (bus.ReqValid) begin
        mAct = 1'b1; mK = 1; mWr = bus.ReqWrite; mAddr = bus.ReqAddr; mData = bus.ReqData;
        acceptCyc.push_back(cyc);
      end
    end
  end

  // Compare every output against the model on the falling edge.
  always @(negedge Clk) begin
    if (chkEn) begin
      bit strobe;
      strobe = mAct && mK > int'(S) && mK <= int'(S + ST);
      chk("ReqReady", bus.ReqReady, !mAct && mInitDone);
      chk("Busy",     bus.Busy,     mAct);
      chk("nCs",      bus.nCs,      !mAct);
      chk("nWr",      bus.nWr,      !(strobe && mWr));
      chk("nRe",      bus.nRe,      !(strobe && !mWr));
      chk("DOe",      bus.DOe,      mAct && mWr);
      chk("A",        bus.A,        mAddr);
      chk("DOut",     bus.DOut,     mData);
      chk("RspValid", bus.RspValid, mRspValid);
      chk("RspData",  bus.RspData,  mRsp);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic waitReady();
    int n = 0;
    while (!bus.ReqReady && n < 100) begin
      tick();
      n++;
    end
    chk("ready_timeout", bus.ReqReady, 1);
  endtask

  // Samples cycles 1..6 after an accept edge.
  task automatic capture6(output logic [5:0] cs, output logic [5:0] wr, output logic [5:0] re,
                          output logic [5:0] rv, output logic [7:0] rdAt4);
    rdAt4 = '0;
    for (int i = 0; i < 6; i++) begin
      cs[i] = bus.nCs;
      wr[i] = bus.nWr;
      re[i] = bus.nRe;
      rv[i] = bus.RspValid;
      if (i == 4) rdAt4 = bus.RspData;
      tick();
    end
  endtask

  logic [5:0] cs, wr, re, rv;
  logic [7:0] rd;
  int         rspReadyOverlap;

  initial begin
    bus.ReqValid = 1'b0;
    bus.ReqWrite = 1'b0;
    bus.ReqAddr  = '0;
    bus.ReqData  = '0;
    bus.DIn      = '0;
    Reset        = 1'b1;
    tick();
    chkEn = 1'b1;
    tick();
    chk("rst_nCs",  bus.nCs,  1);
    chk("rst_Busy", bus.Busy, 0);
    chk("rst_nWr",  bus.nWr,  1);
    Reset = 1'b0;

    // Write 0x55 to port A.
    waitReady();
    bus.ReqValid = 1'b1; bus.ReqWrite = 1'b1; bus.ReqAddr = PPI_ADDR_A; bus.ReqData = 8'h55;
    tick();
    bus.ReqValid = 1'b0; bus.ReqData = 8'hFF;
    capture6(cs, wr, re, rv, rd);
    chk("wr_nCs_pattern", cs, 6'b110000);
    chk("wr_nWr_pattern", wr, 6'b111001);
    chk("wr_nRe_pattern", re, 6'b111111);
    chk("wr_no_rsp",      rv, 6'b000000);

    // Read port B with DIn = 0xA3.
    waitReady();
    bus.DIn = 8'hA3;
    bus.ReqValid = 1'b1; bus.ReqWrite = 1'b0; bus.ReqAddr = PPI_ADDR_B;
    tick();
    bus.ReqValid = 1'b0;
    capture6(cs, wr, re, rv, rd);
    chk("rd_nRe_pattern", re, 6'b111001);
    chk("rd_nWr_pattern", wr, 6'b111111);
    chk("rd_rsp_pattern", rv, 6'b010000);
    chk("rd_data",        rd, 8'hA3);

    // Back-to-back reads with ReqValid held high and changing DIn.
    waitReady();
    rspReadyOverlap = 0;
    bus.ReqValid = 1'b1; bus.ReqWrite = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.DIn     = 8'($urandom);
      bus.ReqAddr = 2'($urandom);
      tick();
      if (bus.RspValid && bus.ReqReady) rspReadyOverlap++;
    end
    bus.ReqValid = 1'b0;
    chk("b2b_period", acceptCyc[acceptCyc.size()-1] - acceptCyc[acceptCyc.size()-2], 5);
    chk("b2b_accept_in_rsp_cycle", rspReadyOverlap >= 2, 1);

    // Reset in the second strobe cycle of a read.
    waitReady();
    bus.ReqValid = 1'b1; bus.ReqWrite = 1'b0; bus.ReqAddr = PPI_ADDR_C;
    tick();
    bus.ReqValid = 1'b0;
    tick();
    tick();
    chk("abort_in_strobe", bus.nRe, 0);
    Reset = 1'b1;
    tick();
    chk("abort_nCs",      bus.nCs,      1);
    chk("abort_nRe",      bus.nRe,      1);
    chk("abort_Busy",     bus.Busy,     0);
    chk("abort_RspValid", bus.RspValid, 0);
    Reset = 1'b0;
    repeat (4) tick();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      bus.ReqValid = ($urandom_range(0, 2) != 0);
      bus.ReqWrite = 1'($urandom);
      bus.ReqAddr  = 2'($urandom);
      bus.ReqData  = 8'($urandom);
      bus.DIn      = 8'($urandom);
      Reset        = ($urandom_range(0, 79) == 0);
      tick();
    end
    Reset = 1'b0;
    bus.ReqValid = 1'b0;
    repeat (10) tick();

    chkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
